// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: fetches 16-bit words from an upstream FIFO and sends each as a start/data/parity/stop serial frame
// Ports:
//   CLK          system clock, shared with the upstream FIFO
//   RST          synchronous active-high reset, aborts any frame in flight
//   EN           1 permits fetching the next word; a started frame always completes
//   QUEUE_EMPTY  empty flag from the FIFO
//   DOUT         FIFO read data, valid the cycle after RD is sampled
//   RD           registered one-cycle read strobe
//   TX           registered serial line, idle high
//   BUSY         high in every state except IDLE
//   WORD_CNT     frames fully transmitted, wraps modulo 2^16
module fifo_word_serializer #(
    parameter int BIT_TICKS = 4,
    parameter int PARITY_EN = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        QUEUE_EMPTY,
    input  logic [15:0] DOUT,
    output logic        RD,
    output logic        TX,
    output logic        BUSY,
    output logic [15:0] WORD_CNT
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] PAR   = 3'd5;
    localparam logic [2:0] STOP  = 3'd6;
    localparam logic [7:0] LAST_TICK = 8'(BIT_TICKS - 1);

    logic [2:0]  state;
    logic [15:0] shreg;
    logic [7:0]  tick;
    logic [4:0]  bit_idx;
    logic        parity;
    logic        timed;
    logic        bit_end;
    logic        fetch;

    // START..STOP are the bit-timed states; the tick counter idles at zero elsewhere
    assign timed   = (state >= START) && (state <= STOP);
    assign bit_end = (tick == LAST_TICK);
    assign fetch   = EN && !QUEUE_EMPTY;
    assign BUSY    = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            RD       <= 1'b0;
            TX       <= 1'b1;
            WORD_CNT <= 16'd0;
            shreg    <= 16'd0;
            tick     <= 8'd0;
            bit_idx  <= 5'd0;
            parity   <= 1'b0;
        end else begin
            RD   <= 1'b0;
            tick <= (timed && !bit_end) ? tick + 8'd1 : 8'd0;
            case (state)
                IDLE: begin
                    RD    <= fetch;
                    state <= fetch ? REQ : IDLE;
                end
                REQ: state <= CAPT;
                CAPT: begin
                    shreg   <= DOUT;
                    parity  <= ^DOUT;
                    bit_idx <= 5'd0;
                    TX      <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        TX    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 5'd15) begin
                            TX    <= (PARITY_EN != 0) ? parity : 1'b1;
                            state <= (PARITY_EN != 0) ? PAR : STOP;
                        end else begin
                            // TX takes the next bit directly so it changes only on the bit boundary
                            shreg   <= shreg >> 1;
                            TX      <= shreg[1];
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        TX    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        WORD_CNT <= WORD_CNT + 16'd1;
                        RD       <= fetch;
                        state    <= fetch ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb_fifo_word_serializer: scoreboard bench for two serializer instances (4 ticks with parity, 1 tick without)
module tb_fifo_word_serializer;
    logic        clk = 1'b0;
    logic        rst_s [2];
    logic        en_s [2];
    logic        qe_s [2];
    logic        rd_s [2];
    logic        tx_s [2];
    logic        busy_s [2];
    logic [15:0] dout_s [2];
    logic [15:0] wcnt_s [2];

    logic [15:0] mem [2][16];
    logic [3:0]  wp [2] = '{4'd0, 4'd0};
    logic [3:0]  rp [2] = '{4'd0, 4'd0};

    // expected frame entry: {goes straight to next fetch, parity bit, word}
    logic [17:0] exp0[$];
    logic [17:0] exp1[$];
    logic        chk_idle [2] = '{1'b0, 1'b0};
    logic        done = 1'b0;

    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fifo_word_serializer u0 (
        .CLK(clk), .RST(rst_s[0]), .EN(en_s[0]), .QUEUE_EMPTY(qe_s[0]), .DOUT(dout_s[0]),
        .RD(rd_s[0]), .TX(tx_s[0]), .BUSY(busy_s[0]), .WORD_CNT(wcnt_s[0])
    );

    fifo_word_serializer #(.BIT_TICKS(1), .PARITY_EN(0)) u1 (
        .CLK(clk), .RST(rst_s[1]), .EN(en_s[1]), .QUEUE_EMPTY(qe_s[1]), .DOUT(dout_s[1]),
        .RD(rd_s[1]), .TX(tx_s[1]), .BUSY(busy_s[1]), .WORD_CNT(wcnt_s[1])
    );

    assign qe_s[0] = (wp[0] == rp[0]);
    assign qe_s[1] = (wp[1] == rp[1]);

    always @(posedge clk) begin
        if (rd_s[0]) begin
            dout_s[0] <= mem[0][rp[0]];
            rp[0]     <= rp[0] + 4'd1;
        end
        if (rd_s[1]) begin
            dout_s[1] <= mem[1][rp[1]];
            rp[1]     <= rp[1] + 4'd1;
        end
    end

    int          pos [2] = '{-1, -1};
    int          bad [2] = '{0, 0};
    logic [15:0] cnt_exp [2] = '{16'd0, 16'd0};
    logic [17:0] cur [2];
    logic        post_rst [2] = '{1'b0, 1'b0};
    logic        rd_prev [2] = '{1'b0, 1'b0};
    logic        done_seen = 1'b0;

    always @(negedge clk) begin
        int   bt;
        int   flen;
        int   b;
        int   n;
        logic e;
        for (int i = 0; i < 2; i++) begin
            bt   = (i == 0) ? 4 : 1;
            flen = ((i == 0) ? 19 : 18) * bt;
            if (post_rst[i]) begin
                checks++;
                if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || rd_s[i] !== 1'b0 || wcnt_s[i] !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_state[%0d]: tx=%b busy=%b rd=%b word_cnt=%0d, required tx=1 busy=0 rd=0 word_cnt=0",
                             i, tx_s[i], busy_s[i], rd_s[i], wcnt_s[i]);
                end
            end
            if (rst_s[i]) begin
                if (pos[i] >= 0) begin
                    checks++;
                    if (bad[i] != 0) begin
                        errors++;
                        $display("FAIL aborted_prefix[%0d]: %0d bit-cycle mismatches, required 0", i, bad[i]);
                    end
                end
                pos[i]      = -1;
                cnt_exp[i]  = 16'd0;
                post_rst[i] = 1'b1;
            end else begin
                post_rst[i] = 1'b0;
                if (rd_s[i]) begin
                    checks++;
                    if (qe_s[i] || rd_prev[i]) begin
                        errors++;
                        $display("FAIL rd_pulse[%0d]: empty=%b rd_prev=%b, required empty=0 rd_prev=0", i, qe_s[i], rd_prev[i]);
                    end
                end
                if (chk_idle[i]) begin
                    checks++;
                    if (rd_s[i] !== 1'b0 || tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || wcnt_s[i] !== cnt_exp[i]) begin
                        errors++;
                        $display("FAIL idle[%0d]: rd=%b tx=%b busy=%b word_cnt=%0d, required rd=0 tx=1 busy=0 word_cnt=%0d",
                                 i, rd_s[i], tx_s[i], busy_s[i], wcnt_s[i], cnt_exp[i]);
                    end
                end
                if (pos[i] == -2) begin
                    cnt_exp[i] = cnt_exp[i] + 16'd1;
                    checks++;
                    if (wcnt_s[i] !== cnt_exp[i] || busy_s[i] !== cur[i][17]) begin
                        errors++;
                        $display("FAIL frame_end[%0d]: word_cnt=%0d busy=%b, required word_cnt=%0d busy=%b",
                                 i, wcnt_s[i], busy_s[i], cnt_exp[i], cur[i][17]);
                    end
                    pos[i] = -1;
                end else if (pos[i] == -1 && busy_s[i] === 1'b1 && tx_s[i] === 1'b0) begin
                    n = (i == 0) ? exp0.size() : exp1.size();
                    if (n == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame[%0d]: frames pending=0, required >0", i);
                        cur[i] = 18'd0;
                    end else begin
                        cur[i] = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                    end
                    pos[i] = 0;
                    bad[i] = 0;
                end
                if (pos[i] >= 0) begin
                    b = pos[i] / bt;
                    if (b == 0) e = 1'b0;
                    else if (b <= 16) e = cur[i][b - 1];
                    else if (b == 17 && i == 0) e = cur[i][16];
                    else e = 1'b1;
                    if (tx_s[i] !== e || busy_s[i] !== 1'b1) bad[i]++;
                    pos[i]++;
                    if (pos[i] == flen) begin
                        checks++;
                        if (bad[i] != 0) begin
                            errors++;
                            $display("FAIL frame[%0d] word=%h: %0d bit-cycle mismatches, required 0", i, cur[i][15:0], bad[i]);
                        end
                        checks++;
                        if (wcnt_s[i] !== cnt_exp[i]) begin
                            errors++;
                            $display("FAIL word_cnt_early[%0d]: word_cnt=%0d in last stop cycle, required %0d", i, wcnt_s[i], cnt_exp[i]);
                        end
                        pos[i] = -2;
                    end
                end
            end
            rd_prev[i] = rd_s[i];
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            checks++;
            if (exp0.size() != 0 || exp1.size() != 0) begin
                errors++;
                $display("FAIL missing_frames: pending=%0d/%0d, required 0/0", exp0.size(), exp1.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [15:0] w, input logic p, input logic nd);
        mem[i][wp[i]] = w;
        wp[i] = wp[i] + 4'd1;
        if (i == 0) exp0.push_back({nd, p, w});
        else exp1.push_back({nd, p, w});
    endtask

    task automatic reset_dut(input int i);
        rst_s[i] = 1'b1;
        cyc(3);
        rst_s[i] = 1'b0;
    endtask

    task automatic idle_window(input int i, input int n);
        chk_idle[i] = 1'b1;
        cyc(n);
        chk_idle[i] = 1'b0;
    endtask

    initial begin
        rst_s = '{1'b1, 1'b1};
        en_s  = '{1'b0, 1'b0};
        cyc(4);
        rst_s = '{1'b0, 1'b0};
        // empty FIFO with EN high: nothing may happen
        en_s[0] = 1'b1;
        idle_window(0, 100);
        // single word, parity 0
        push(0, 16'hA5C3, 1'b0, 1'b0);
        cyc(90);
        idle_window(0, 5);
        // three back-to-back words, parities 1,0,1
        reset_dut(0);
        push(0, 16'h0001, 1'b1, 1'b1);
        push(0, 16'hFFFF, 1'b0, 1'b1);
        push(0, 16'h8000, 1'b1, 1'b0);
        cyc(245);
        idle_window(0, 10);
        // EN dropped mid-frame blocks the second fetch only
        reset_dut(0);
        push(0, 16'h0F01, 1'b1, 1'b0);
        push(0, 16'h1357, 1'b0, 1'b0);
        cyc(20);
        en_s[0] = 1'b0;
        cyc(80);
        idle_window(0, 20);
        en_s[0] = 1'b1;
        cyc(90);
        idle_window(0, 5);
        // reset during data bit 8 aborts the frame; the next word goes out whole
        reset_dut(0);
        push(0, 16'hBEEF, 1'b1, 1'b0);
        push(0, 16'h0C30, 1'b0, 1'b0);
        cyc(39);
        rst_s[0] = 1'b1;
        cyc(1);
        rst_s[0] = 1'b0;
        cyc(90);
        idle_window(0, 5);
        // one tick per bit, no parity: 18-cycle frames
        idle_window(1, 3);
        en_s[1] = 1'b1;
        push(1, 16'h1234, 1'b1, 1'b1);
        push(1, 16'h8001, 1'b0, 1'b0);
        cyc(50);
        idle_window(1, 3);
        done = 1'b1;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 4: CLK cycles per serial bit; legal range 1..255.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 inserts one even-parity bit after the data bits; 0 omits it.
REQ-003 SHALL have a single clock, port CLK; all state updates occur on posedge CLK.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLK  input  1  system clock, shared with the upstream FIFO.
REQ-006 SHALL have port EN  input  1  1 permits fetching a new word; the current frame always completes.
REQ-007 SHALL have port QUEUE_EMPTY  input  1  empty flag from the upstream FIFO.
REQ-008 SHALL have port DOUT  input  16  read data from the FIFO, valid on the cycle after a RD pulse is sampled.
REQ-009 SHALL have port RD  output  1  registered one-cycle read strobe to the FIFO.
REQ-010 SHALL have port TX  output  1  serial line, idle high.
REQ-011 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-012 SHALL have port WORD_CNT  output  16  count of frames fully transmitted, wraps modulo 2^16.

Function
REQ-013 SHALL implement the states IDLE, REQ, CAPT, START, DATA, PAR and STOP.
REQ-014 IDLE: if EN=1 and QUEUE_EMPTY=0, the next edge SHALL set RD=1 and go to REQ; otherwise stay in IDLE with RD=0 and TX=1.
REQ-015 REQ: the next edge SHALL clear RD and go to CAPT, so RD is high for exactly one cycle per word.
REQ-016 CAPT: the next edge SHALL latch DOUT into a 16-bit shift register, compute even parity (XOR of all 16 bits), and go to START.
REQ-017 START: TX SHALL be 0 for BIT_TICKS cycles, then go to DATA.
REQ-018 DATA: TX SHALL output shift register bit 0 for BIT_TICKS cycles per bit, then shift right; 16 bits are sent LSB first.
REQ-019 After the 16th data bit, the state SHALL go to PAR if PARITY_EN=1, otherwise to STOP.
REQ-020 PAR: TX SHALL output the parity bit for BIT_TICKS cycles, then go to STOP.
REQ-021 STOP: TX SHALL be 1 for BIT_TICKS cycles.
REQ-022 At the end of STOP, WORD_CNT SHALL increment by 1.
REQ-023 At the end of STOP, if EN=1 and QUEUE_EMPTY=0, the state SHALL go directly to REQ with RD=1 (back-to-back frames, no extra idle bit); otherwise go to IDLE.
REQ-024 Frame length SHALL be 19*BIT_TICKS cycles with parity and 18*BIT_TICKS without.
REQ-025 The bit-tick counter SHALL be 8 bits wide, count 0..BIT_TICKS-1, and clear on every bit boundary.
REQ-026 The data-bit index SHALL be 5 bits wide and count 0..15.
REQ-027 TX SHALL be registered and glitch-free; it SHALL change only on bit boundaries.
REQ-028 Dropping EN mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-029 QUEUE_EMPTY SHALL be sampled only in IDLE and at the end of STOP; changes at any other time SHALL be ignored.
REQ-030 The block SHALL NOT assert RD while QUEUE_EMPTY=1, and SHALL never assert RD twice for one word.

Reset
REQ-031 While RST=1 at a posedge, the block SHALL set state=IDLE, RD=0, TX=1, BUSY=0, WORD_CNT=0, and clear the shift register, counters and parity bit.
REQ-032 RST mid-frame SHALL abort the frame; TX SHALL return high at that edge, the word in flight is discarded, and WORD_CNT is not incremented.
REQ-033 RST SHALL take priority over all other inputs.

Verification
REQ-034 Reset, then hold QUEUE_EMPTY=1 and EN=1 for 100 cycles -> RD=0, TX=1, BUSY=0, WORD_CNT=0 throughout.
REQ-035 One word 16'hA5C3 in the FIFO, BIT_TICKS=4, PARITY_EN=1 -> exactly one RD pulse; TX sends start 0, data bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), parity 0, stop 1, each bit 4 cycles; WORD_CNT=1; BUSY returns to 0.
REQ-036 Three words 16'h0001, 16'hFFFF, 16'h8000 queued -> three RD pulses, no idle gap between frames, parity bits 1,0,1, WORD_CNT=3, then RD stops while QUEUE_EMPTY=1.
REQ-037 EN dropped to 0 during DATA of the first of two queued words -> the first frame completes, no second RD pulse, WORD_CNT=1; raise EN again -> the second word is sent.
REQ-038 RST pulsed for one cycle during bit 8 of DATA -> TX=1 and BUSY=0 on the next cycle, WORD_CNT=0; the next queued word is then sent as a full frame.
REQ-039 PARITY_EN=0, BIT_TICKS=1, word 16'h1234 -> frame is 18 cycles with no parity bit, and WORD_CNT increments on cycle 18.
